// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg
//   Declarations shared by the register-bus master, its bus interface and its
//   timeout counter:
//     state_t            - master FSM states (IDLE, REQ, WAIT, RESP)
//     cmd_t              - held command (write, addr, wdata, wstrb)
//     REG_BUS_*_W        - bus widths the held command is sized for
//     TIMEOUT_CYCLES_DEF - default READY wait limit
//   Optional feature macro elsewhere in the slice: REG_BUS_MASTER_TIMEOUT_EN.
package reg_bus_pkg;

  localparam int unsigned REG_BUS_ADDR_W     = 32;
  localparam int unsigned REG_BUS_DATA_W     = 32;
  localparam int unsigned REG_BUS_STRB_W     = REG_BUS_DATA_W / 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic                      write;
    logic [REG_BUS_ADDR_W-1:0] addr;
    logic [REG_BUS_DATA_W-1:0] wdata;
    logic [REG_BUS_STRB_W-1:0] wstrb;
  } cmd_t;

endpackage

// File: rtl/memory_32_32_if.sv
// memory_32_32
//   Simple register bus between one initiator and one register block.
//   Signals: ADDR (byte address), DATA_WR, WSTRB, WE, RE driven by the
//   initiator; DATA_RD and READY driven by the target.
//   Modports: outward (initiator side), inward (target side).
interface memory_32_32
  import reg_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_BUS_ADDR_W,
  parameter int unsigned DATA_W = REG_BUS_DATA_W
);

  logic [ADDR_W-1:0]   ADDR;
  logic [DATA_W-1:0]   DATA_WR;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WE;
  logic                RE;
  logic [DATA_W-1:0]   DATA_RD;
  logic                READY;

  modport outward (
    output ADDR, DATA_WR, WSTRB, WE, RE,
    input  DATA_RD, READY
  );

  modport inward (
    input  ADDR, DATA_WR, WSTRB, WE, RE,
    output DATA_RD, READY
  );

endinterface

// File: rtl/reg_bus_timeout_ctr.sv
// reg_bus_timeout_ctr
//   Counts WAIT cycles for the register-bus master. Only built when
//   REG_BUS_MASTER_TIMEOUT_EN is defined.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     clear     - zero the count (the master's REQ cycle)
//     enable    - count this cycle (the master is in WAIT)
//     expired   - high during the TIMEOUT_CYCLES-th WAIT cycle
module reg_bus_timeout_ctr
  import reg_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A zero limit would never expire; treat it as one cycle.
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The count is 0 in the first WAIT cycle, so LIMIT-1 marks the last one.
  assign expired = (count_q == CNT_W'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master
//   Turns single commands into register-bus transactions, one outstanding at
//   a time: IDLE -> REQ (one cycle) -> WAIT (until READY) -> RESP.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     cmd_valid/cmd_ready               command handshake
//     cmd_write/addr/wdata/wstrb        command payload
//     rsp_valid/rsp_ready               response handshake
//     rsp_rdata, rsp_err                read data (0 for writes/errors), timeout
//     regs                              memory_32_32.outward bus initiator
//   Macro REG_BUS_MASTER_TIMEOUT_EN: when defined, a WAIT lasting
//   TIMEOUT_CYCLES cycles without READY ends with rsp_err=1. When undefined
//   WAIT lasts until READY and rsp_err is always 0.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = REG_BUS_ADDR_W,
  parameter int unsigned DATA_W         = REG_BUS_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  memory_32_32.outward        regs
);

  state_t              state_q;
  state_t              state_d;
  cmd_t                cmd_q;
  cmd_t                cmd_d;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                rsp_err_q;
  logic                rsp_err_d;
  logic                timeout_expired;
  logic                bus_active;

`ifdef REG_BUS_MASTER_TIMEOUT_EN
  reg_bus_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == REQ),
    .enable  (state_q == WAIT),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  // Next state and captured response. READY only matters in WAIT, so READY
  // seen in REQ or while the bus is idle has no effect.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = cmd_addr;
          cmd_d.wdata = cmd_wdata;
          cmd_d.wstrb = cmd_wstrb;
          state_d     = REQ;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // READY wins over a timeout expiring in the same cycle.
        if (regs.READY) begin
          rsp_rdata_d = cmd_q.write ? '0 : regs.DATA_RD;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (timeout_expired) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Bus outputs decode registered state only, so they are held stable
  // through WAIT and drop to zero in RESP/IDLE, which guarantees a gap of
  // at least one low WE/RE cycle between transactions.
  assign bus_active    = (state_q == REQ) || (state_q == WAIT);
  assign regs.ADDR     = bus_active ? cmd_q.addr : '0;
  assign regs.DATA_WR  = (bus_active && cmd_q.write) ? cmd_q.wdata : '0;
  assign regs.WSTRB    = (bus_active && cmd_q.write) ? cmd_q.wstrb : '0;
  assign regs.WE       = bus_active && cmd_q.write;
  assign regs.RE       = bus_active && !cmd_q.write;

  // cmd_ready is masked by rst so it reads 0 while reset is held.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_bus_master.sv
module tb_reg_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  memory_32_32 regs_if ();

  reg_bus_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .regs(regs_if)
  );

  // ---------------- responder: testRegBlock model (4 words) ----------------
  logic [31:0] model_reg [0:3];
  int act_cnt;
  int ready_delay = 0;
  bit ready_en = 1'b1;
  bit ready_always = 1'b0;
  wire bus_act = regs_if.WE | regs_if.RE;

  // act_cnt is 0 in the REQ cycle and k in the k-th WAIT cycle.
  assign regs_if.READY   = ready_always | (ready_en & bus_act & (act_cnt >= ready_delay + 1));
  assign regs_if.DATA_RD = model_reg[regs_if.ADDR[3:2]];

  always @(posedge clk) begin
    if (rst) begin
      act_cnt      <= 0;
      model_reg[0] <= 32'h0;
      model_reg[1] <= 32'h0;
      model_reg[2] <= 32'h00200010;
      model_reg[3] <= 32'h0;
    end else begin
      act_cnt <= bus_act ? act_cnt + 1 : 0;
      if (regs_if.WE && regs_if.READY && act_cnt != 0) begin
        for (int b = 0; b < 4; b++) begin
          if (regs_if.WSTRB[b]) model_reg[regs_if.ADDR[3:2]][8*b +: 8] <= regs_if.DATA_WR[8*b +: 8];
        end
      end
    end
  end

  // ---------------- bus monitor (monotonic counters) ----------------
  int we_cnt = 0, re_cnt = 0, rise_cnt = 0, unstable_cnt = 0, both_cnt = 0, rd_dirty_cnt = 0;
  bit prev_act = 1'b0;
  logic [31:0] prev_addr = '0, prev_wd = '0, last_wdata = '0;
  logic [3:0]  prev_strb = '0, last_wstrb = '0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (regs_if.WE) begin
      we_cnt     <= we_cnt + 1;
      last_wdata <= regs_if.DATA_WR;
      last_wstrb <= regs_if.WSTRB;
    end
    if (regs_if.RE) re_cnt <= re_cnt + 1;
    if (regs_if.WE && regs_if.RE) both_cnt <= both_cnt + 1;
    if (regs_if.RE && (regs_if.WSTRB != 4'h0 || regs_if.DATA_WR != 32'h0)) rd_dirty_cnt <= rd_dirty_cnt + 1;
    if (bus_act && !prev_act) rise_cnt <= rise_cnt + 1;
    if (bus_act && prev_act && (regs_if.ADDR != prev_addr || regs_if.DATA_WR != prev_wd ||
        regs_if.WSTRB != prev_strb || regs_if.WE != prev_we)) unstable_cnt <= unstable_cnt + 1;
    prev_act  <= bus_act;
    prev_addr <= regs_if.ADDR;
    prev_wd   <= regs_if.DATA_WR;
    prev_strb <= regs_if.WSTRB;
    prev_we   <= regs_if.WE;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output bit ok);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    if (ok) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    $display("txn cmd %s addr=%h wdata=%h wstrb=%h accepted=%0d", w ? "WR" : "RD", a, d, s, ok);
  endtask

  task automatic wait_rsp(input int limit, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (lat < limit && !got) begin
      @(negedge clk);
      lat++;
      got = rsp_valid;
    end
    $display("txn rsp seen=%0d after=%0d rdata=%h err=%0d", got, lat, rsp_rdata, rsp_err);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
    total++; if ({regs_if.ADDR, regs_if.DATA_WR, regs_if.WSTRB, regs_if.WE, regs_if.RE} !== 70'h0) begin
      bad++; $display("FAIL rst_bus got addr=%h wd=%h strb=%h we=%b re=%b exp all 0",
                      regs_if.ADDR, regs_if.DATA_WR, regs_if.WSTRB, regs_if.WE, regs_if.RE); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    bit ok, got; int lat; int we0 = we_cnt, re0 = re_cnt;
    send_cmd(1'b1, 32'h00, 32'h12345678, 4'hF, ok);
    wait_rsp(20, lat, got);
    total++; if (got !== 1'b1 || lat != 3) begin bad++; $display("FAIL wr_latency got=%0d seen=%0d exp=3", lat, got); end
    total++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp got err=%b rdata=%h exp 0/0", rsp_err, rsp_rdata); end
    finish_rsp();
    total++; if (we_cnt - we0 != 2 || re_cnt - re0 != 0) begin bad++; $display("FAIL wr_strobes got we=%0d re=%0d exp 2/0", we_cnt - we0, re_cnt - re0); end
    total++; if (last_wdata !== 32'h12345678 || last_wstrb !== 4'hF) begin bad++; $display("FAIL wr_bus got %h/%h exp 12345678/f", last_wdata, last_wstrb); end
    total++; if (model_reg[0] !== 32'h12345678) begin bad++; $display("FAIL wr_reg0 got=%h exp=12345678", model_reg[0]); end
  endtask

  task automatic test_read();
    bit ok, got; int lat; int re0 = re_cnt, dirty0 = rd_dirty_cnt;
    send_cmd(1'b0, 32'h08, 32'hFFFFFFFF, 4'hF, ok);
    wait_rsp(20, lat, got);
    total++; if (got !== 1'b1 || lat != 3) begin bad++; $display("FAIL rd_latency got=%0d seen=%0d exp=3", lat, got); end
    total++; if (rsp_rdata !== 32'h00200010 || rsp_err !== 1'b0) begin bad++; $display("FAIL rd_reg2 got=%h err=%b exp=00200010/0", rsp_rdata, rsp_err); end
    finish_rsp();
    total++; if (re_cnt - re0 != 2 || rd_dirty_cnt != dirty0) begin bad++; $display("FAIL rd_bus got re=%0d dirty=%0d exp 2/0", re_cnt - re0, rd_dirty_cnt - dirty0); end
    send_cmd(1'b0, 32'h00, 32'h0, 4'h0, ok);
    wait_rsp(20, lat, got);
    total++; if (rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_reg0 got=%h exp=12345678", rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_wait_states();
    bit ok, got; int lat; int re0 = re_cnt, un0 = unstable_cnt;
    ready_delay = 5;
    send_cmd(1'b0, 32'h00, 32'h0, 4'h0, ok);
    wait_rsp(30, lat, got);
    total++; if (got !== 1'b1 || lat != 8) begin bad++; $display("FAIL ws_latency got=%0d seen=%0d exp=8", lat, got); end
    total++; if (rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0) begin bad++; $display("FAIL ws_rsp got=%h err=%b exp=12345678/0", rsp_rdata, rsp_err); end
    finish_rsp();
    total++; if (re_cnt - re0 != 7) begin bad++; $display("FAIL ws_re_cycles got=%0d exp=7", re_cnt - re0); end
    total++; if (unstable_cnt != un0) begin bad++; $display("FAIL ws_stable got=%0d changes exp=0", unstable_cnt - un0); end
    ready_delay = 0;
  endtask

  task automatic test_ready_ignored();
    bit ok, got; int lat; int we0 = we_cnt;
    ready_always = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({regs_if.WE, regs_if.RE, rsp_valid} !== 3'b000) begin bad++; $display("FAIL idle_ready got=%b exp=000", {regs_if.WE, regs_if.RE, rsp_valid}); end
    end
    send_cmd(1'b1, 32'h04, 32'hAABBCCDD, 4'h3, ok);
    wait_rsp(20, lat, got);
    total++; if (got !== 1'b1 || lat != 3) begin bad++; $display("FAIL early_ready_latency got=%0d seen=%0d exp=3", lat, got); end
    finish_rsp();
    total++; if (we_cnt - we0 != 2) begin bad++; $display("FAIL early_ready_we got=%0d exp=2", we_cnt - we0); end
    ready_always = 1'b0;
    send_cmd(1'b0, 32'h04, 32'h0, 4'h0, ok);
    wait_rsp(20, lat, got);
    total++; if (rsp_rdata !== 32'h0000CCDD) begin bad++; $display("FAIL wstrb_partial got=%h exp=0000ccdd", rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    bit ok, got; int lat; int r0 = rise_cnt, b0 = both_cnt;
    rsp_ready = 1'b1;
    send_cmd(1'b1, 32'h0C, 32'h11111111, 4'hF, ok);
    wait_rsp(20, lat, got);
    send_cmd(1'b0, 32'h0C, 32'h0, 4'h0, ok);
    wait_rsp(20, lat, got);
    total++; if (got !== 1'b1 || rsp_rdata !== 32'h11111111) begin bad++; $display("FAIL b2b_rdata got=%h seen=%0d exp=11111111", rsp_rdata, got); end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    total++; if (rise_cnt - r0 != 2 || both_cnt != b0) begin bad++; $display("FAIL b2b_gap got rises=%0d both=%0d exp 2/0", rise_cnt - r0, both_cnt - b0); end
  endtask

  task automatic test_rsp_backpressure();
    bit ok, got; int lat;
    send_cmd(1'b0, 32'h08, 32'h0, 4'h0, ok);
    wait_rsp(20, lat, got);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0C; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00200010 || cmd_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got v=%b rdata=%h crdy=%b exp 1/00200010/0", i, rsp_valid, rsp_rdata, cmd_ready); end
      @(negedge clk);
    end
    finish_rsp();
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_cmd_ready got=%b exp=1", cmd_ready); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    $display("txn cmd WR addr=0000000c wdata=00000055 wstrb=f held through backpressure");
    wait_rsp(20, lat, got);
    total++; if (got !== 1'b1 || lat != 3) begin bad++; $display("FAIL bp_next_latency got=%0d seen=%0d exp=3", lat, got); end
    finish_rsp();
    total++; if (model_reg[3] !== 32'h55) begin bad++; $display("FAIL bp_next_write got=%h exp=00000055", model_reg[3]); end
  endtask

  task automatic test_no_ready();
    bit ok, got; int lat;
    ready_en = 1'b0;
    send_cmd(1'b0, 32'h08, 32'h0, 4'h0, ok);
    wait_rsp(40, lat, got);
`ifdef REG_BUS_MASTER_TIMEOUT_EN
    total++; if (got !== 1'b1 || lat != 18) begin bad++; $display("FAIL to_latency got=%0d seen=%0d exp=18", lat, got); end
    total++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rsp got err=%b rdata=%h exp 1/0", rsp_err, rsp_rdata); end
    total++; if ({regs_if.WE, regs_if.RE} !== 2'b00) begin bad++; $display("FAIL to_bus_idle got=%b exp=00", {regs_if.WE, regs_if.RE}); end
    finish_rsp();
`else
    total++; if (got !== 1'b0) begin bad++; $display("FAIL hold_no_rsp got=%b exp=0", got); end
    total++; if (regs_if.RE !== 1'b1) begin bad++; $display("FAIL hold_re got=%b exp=1", regs_if.RE); end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok, got; int lat; int seen = 0;
    ready_en = 1'b0;
    if (cmd_ready) send_cmd(1'b1, 32'h00, 32'hDEADBEEF, 4'hF, ok);
    repeat (3) @(negedge clk);
    total++; if (bus_act !== 1'b1) begin bad++; $display("FAIL mid_in_wait got=%b exp=1", bus_act); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("txn reset pulse during WAIT");
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_hs got crdy=%b v=%b exp 1/0", cmd_ready, rsp_valid); end
    total++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL mid_rst_rsp got=%h err=%b exp 0/0", rsp_rdata, rsp_err); end
    total++; if ({regs_if.ADDR, regs_if.DATA_WR, regs_if.WSTRB, regs_if.WE, regs_if.RE} !== 70'h0) begin
      bad++; $display("FAIL mid_rst_bus got addr=%h wd=%h strb=%h we=%b re=%b exp all 0",
                      regs_if.ADDR, regs_if.DATA_WR, regs_if.WSTRB, regs_if.WE, regs_if.RE); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_rst_dropped got=%0d rsp cycles exp=0", seen); end
    ready_en = 1'b1;
    send_cmd(1'b1, 32'h00, 32'hCAFEF00D, 4'hF, ok);
    wait_rsp(20, lat, got);
    total++; if (got !== 1'b1 || lat != 3 || rsp_err !== 1'b0) begin bad++; $display("FAIL mid_after_wr got lat=%0d seen=%0d err=%b exp 3/1/0", lat, got, rsp_err); end
    finish_rsp();
    total++; if (model_reg[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL mid_after_reg0 got=%h exp=cafef00d", model_reg[0]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_ready_ignored();
    test_back_to_back();
    test_rsp_backpressure();
    test_no_ready();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
